// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 scan code set 2 key tracker.
// Holds the decoder states, prefix bytes, default key table and event layout.
package ps2_kbd_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int KEY_IDX_MAX_W = 5;

   // Entry 0 is the rightmost element: a, b, c, d, up, down, left, right.
   localparam logic [8*9-1:0] KEY_CODES_DEF = {
      9'h174, 9'h16B, 9'h172, 9'h175,
      9'h023, 9'h021, 9'h032, 9'h01C
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } kbd_state_t;

   typedef struct packed {
      logic [KEY_IDX_MAX_W-1:0] key;
      logic                     make;
   } kbd_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; callers never push while full
// unless popping in the same cycle.
module ps2_evt_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head is masked while empty so the output reads zero after reset.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// Scan code set 2 decoder with per-key held state and a press/release
// event queue; a prefix timeout drops truncated E0/F0 sequences.
module ps2_key_tracker
   import ps2_kbd_pkg::*;
#(
   parameter int                    NUM_KEYS    = 8,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = KEY_CODES_DEF,
   parameter int                    FIFO_DEPTH  = 8,
   parameter int                    TIMEOUT_CYC = 100000,
   parameter int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx_done_tick,
   input  logic [7:0]          rx_data,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [IDX_W-1:0]    evt_key,
   output logic                evt_make,
   output logic                evt_overflow
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC - 1);

   kbd_state_t       state;
   logic [CNT_W-1:0] to_cnt;

   logic             is_pfx;
   logic             do_lookup;
   logic             lk_ext;
   logic             lk_make;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic             evt_push;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   kbd_evt_t         fifo_din;
   kbd_evt_t         fifo_dout;

   assign is_pfx = (rx_data == PS2_EXT) || (rx_data == PS2_BRK);

   always_comb begin
      do_lookup = 1'b0;
      lk_ext    = 1'b0;
      lk_make   = 1'b1;
      unique case (state)
         ST_IDLE: begin
            do_lookup = rx_done_tick & ~is_pfx;
         end
         ST_EXT: begin
            do_lookup = rx_done_tick & ~is_pfx;
            lk_ext    = 1'b1;
         end
         ST_BRK: begin
            do_lookup = rx_done_tick;
            lk_make   = 1'b0;
         end
         ST_EXT_BRK: begin
            do_lookup = rx_done_tick;
            lk_ext    = 1'b1;
            lk_make   = 1'b0;
         end
         default: ;
      endcase
   end

   // Scan downward so the lowest matching index is the one kept.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (KEY_CODES[9*i +: 9] == {lk_ext, rx_data}) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign evt_push  = do_lookup & hit & (lk_make ^ key_held[hit_idx]);
   assign fifo_pop  = evt_ready & ~fifo_empty;
   assign fifo_push = evt_push & (~fifo_full | fifo_pop);

   assign fifo_din.key  = KEY_IDX_MAX_W'(hit_idx);
   assign fifo_din.make = lk_make;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         to_cnt <= '0;
      end else if (rx_done_tick) begin
         to_cnt <= '0;
         unique case (state)
            ST_IDLE: begin
               if (rx_data == PS2_EXT)
                  state <= ST_EXT;
               else if (rx_data == PS2_BRK)
                  state <= ST_BRK;
            end
            ST_EXT: begin
               if (rx_data == PS2_BRK)
                  state <= ST_EXT_BRK;
               else if (rx_data != PS2_EXT)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end else if (state != ST_IDLE) begin
         if (to_cnt == TO_MAX) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_held     <= '0;
         evt_overflow <= 1'b0;
      end else begin
         if (evt_push)
            key_held[hit_idx] <= lk_make;
         if (evt_push & fifo_full & ~fifo_pop)
            evt_overflow <= 1'b1;
      end
   end

   ps2_evt_fifo #(
      .WIDTH ($bits(kbd_evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_valid = ~fifo_empty;
   assign evt_key   = fifo_dout.key[IDX_W-1:0];
   assign evt_make  = fifo_dout.make;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: byte table with expected held
// state and events, plus hand sequences for overflow, timeout and reset.
module tb_ps2_key_tracker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] key_held;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [2:0] evt_key;
   logic       evt_make;
   logic       evt_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ps2_key_tracker #(
      .NUM_KEYS    (8),
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .key_held     (key_held),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_key      (evt_key),
      .evt_make     (evt_make),
      .evt_overflow (evt_overflow)
   );

   typedef struct {
      logic [7:0] b;
      logic [7:0] held;
      logic       ev;
      logic [2:0] k;
      logic       m;
   } vec_t;

   vec_t       tv [22];
   logic [3:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pop_evt(input string name, input logic [2:0] k,
                          input logic m);
      check({name, " valid"}, 32'(evt_valid), 32'd1);
      check({name, " key"}, 32'(evt_key), 32'(k));
      check({name, " make"}, 32'(evt_make), 32'(m));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   initial begin
      tv[0]  = '{8'h1C, 8'h01, 1'b1, 3'd0, 1'b1};
      tv[1]  = '{8'hF0, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[2]  = '{8'h1C, 8'h00, 1'b1, 3'd0, 1'b0};
      tv[3]  = '{8'hE0, 8'h00, 1'b0, 3'd0, 1'b0};
      tv[4]  = '{8'h75, 8'h10, 1'b1, 3'd4, 1'b1};
      tv[5]  = '{8'hE0, 8'h10, 1'b0, 3'd0, 1'b0};
      tv[6]  = '{8'hF0, 8'h10, 1'b0, 3'd0, 1'b0};
      tv[7]  = '{8'h75, 8'h00, 1'b1, 3'd4, 1'b0};
      tv[8]  = '{8'h75, 8'h00, 1'b0, 3'd0, 1'b0};
      tv[9]  = '{8'h1C, 8'h01, 1'b1, 3'd0, 1'b1};
      tv[10] = '{8'h1C, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[11] = '{8'h1C, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[12] = '{8'h1C, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[13] = '{8'h1C, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[14] = '{8'hAA, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[15] = '{8'hE0, 8'h01, 1'b0, 3'd0, 1'b0};
      tv[16] = '{8'h6B, 8'h41, 1'b1, 3'd6, 1'b1};
      tv[17] = '{8'h32, 8'h43, 1'b1, 3'd1, 1'b1};
      tv[18] = '{8'hF0, 8'h43, 1'b0, 3'd0, 1'b0};
      tv[19] = '{8'h32, 8'h41, 1'b1, 3'd1, 1'b0};
      tv[20] = '{8'hF0, 8'h41, 1'b0, 3'd0, 1'b0};
      tv[21] = '{8'h23, 8'h41, 1'b0, 3'd0, 1'b0};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst held", 32'(key_held), 32'h00);
      check("rst valid", 32'(evt_valid), 32'd0);
      check("rst key", 32'(evt_key), 32'd0);
      check("rst make", 32'(evt_make), 32'd0);
      check("rst ovf", 32'(evt_overflow), 32'd0);

      // Byte table, consumer stalled; events drained afterwards in order.
      for (int i = 0; i < 22; i++) begin
         send_byte(tv[i].b);
         check($sformatf("tbl held %0d", i), 32'(key_held),
               32'(tv[i].held));
         if (tv[i].ev)
            exp_q.push_back({tv[i].k, tv[i].m});
      end
      check("tbl ovf", 32'(evt_overflow), 32'd0);
      while (exp_q.size() > 0) begin
         logic [3:0] e;
         e = exp_q.pop_front();
         pop_evt("tbl evt", e[3:1], e[0]);
      end
      check("tbl drained", 32'(evt_valid), 32'd0);

      // Back-to-back ticks.
      do_reset();
      @(negedge clk);
      rx_done_tick = 1'b1;
      rx_data = 8'h1C;
      @(negedge clk);
      rx_data = 8'h32;
      @(negedge clk);
      rx_data = 8'hF0;
      @(negedge clk);
      rx_data = 8'h1C;
      @(negedge clk);
      rx_done_tick = 1'b0;
      check("b2b held", 32'(key_held), 32'h02);
      pop_evt("b2b e0", 3'd0, 1'b1);
      pop_evt("b2b e1", 3'd1, 1'b1);
      pop_evt("b2b e2", 3'd0, 1'b0);
      check("b2b drained", 32'(evt_valid), 32'd0);

      // Push and pop on an empty FIFO in the same cycle.
      do_reset();
      @(negedge clk);
      evt_ready = 1'b1;
      rx_data = 8'h1C;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
      check("emp pp valid", 32'(evt_valid), 32'd1);
      check("emp pp key", 32'(evt_key), 32'd0);
      @(negedge clk);
      evt_ready = 1'b0;
      check("emp pp popped", 32'(evt_valid), 32'd0);

      // Overflow: 8 makes fill the FIFO, the 9th event is dropped.
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h32);
      send_byte(8'h21);
      send_byte(8'h23);
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'h72);
      send_byte(8'hE0); send_byte(8'h6B);
      send_byte(8'hE0); send_byte(8'h74);
      check("ovf pre", 32'(evt_overflow), 32'd0);
      send_byte(8'hF0); send_byte(8'h1C);
      check("ovf flag", 32'(evt_overflow), 32'd1);
      check("ovf held", 32'(key_held), 32'hFE);
      for (int i = 0; i < 8; i++)
         pop_evt($sformatf("ovf e%0d", i), 3'(i), 1'b1);
      check("ovf drained", 32'(evt_valid), 32'd0);
      check("ovf sticky", 32'(evt_overflow), 32'd1);
      do_reset();
      check("ovf cleared", 32'(evt_overflow), 32'd0);

      // Full FIFO with a pop in the same cycle as a new event.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] codes;
         codes = 32'h2321321C;
         send_byte(codes[8*i +: 8]);
      end
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'h72);
      send_byte(8'hE0); send_byte(8'h6B);
      send_byte(8'hE0); send_byte(8'h74);
      send_byte(8'hF0);
      @(negedge clk);
      rx_data = 8'h1C;
      rx_done_tick = 1'b1;
      evt_ready = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
      evt_ready = 1'b0;
      check("fpp ovf", 32'(evt_overflow), 32'd0);
      check("fpp held", 32'(key_held), 32'hFE);
      for (int i = 1; i < 8; i++)
         pop_evt($sformatf("fpp e%0d", i), 3'(i), 1'b1);
      pop_evt("fpp last", 3'd0, 1'b0);
      check("fpp drained", 32'(evt_valid), 32'd0);

      // Prefix still honoured a few cycles after E0.
      do_reset();
      send_byte(8'hE0);
      repeat (3) @(negedge clk);
      send_byte(8'h75);
      check("no to held", 32'(key_held), 32'h10);

      // Timeout abandons the E0 prefix.
      do_reset();
      send_byte(8'hE0);
      repeat (20) @(negedge clk);
      send_byte(8'h1C);
      check("to held", 32'(key_held), 32'h01);
      pop_evt("to evt", 3'd0, 1'b1);

      // Reset after E0 behaves the same way.
      do_reset();
      send_byte(8'hE0);
      do_reset();
      send_byte(8'h1C);
      check("rst pfx held", 32'(key_held), 32'h01);
      pop_evt("rst pfx evt", 3'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
